// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding,
// abort-cause codes and the instruction word width. Honors BOOT_CHECKSUM_EN.
package boot_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 17;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

    // S_CSUM only exists when the trailing checksum byte is actually verified.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERROR
`ifdef BOOT_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } boot_state_t;

    // States in which a frame is being received and the inter-byte timer runs.
    function automatic logic in_frame(input boot_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA: r = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            S_CSUM:                     r = 1'b1;
`endif
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte timeout: counts clocks since the last reload while enabled and
// flags expiry on the TIMEOUT_CYCLES-th consecutive clock without a reload.
module boot_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // A reload in the same cycle always wins, so a byte arriving on the last
    // permitted clock is never lost to the timer.
    assign expired = enable && !reload && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// UART boot loader: parses SYNC, LEN_LO, LEN_HI, LEN little-endian words and an
// optional checksum byte, writing words to instruction memory. BOOT_CHECKSUM_EN
// enables the XOR checksum check.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          CLK_FREQ       = 100_000_000,
    parameter int          TIMEOUT_CYCLES = CLK_FREQ / 100,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_wr,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_WIDTH;

    boot_state_t       state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [CNT_W-1:0]  word_cnt;
    logic [1:0]        byte_idx;
    logic              sync_hit;
    logic              frame_active;
    logic              tmo_expired;
    logic [CNT_W-1:0]  len_next;
    logic              last_word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign sync_hit     = rx_wr && (rx_data == SYNC_BYTE);
    assign frame_active = in_frame(state);
    assign len_next     = {1'b0, rx_data, len_lo};
    assign last_word    = (word_cnt + CNT_W'(1)) == {1'b0, len};

    boot_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .reload  (rx_wr),
        .enable  (frame_active),
        .expired (tmo_expired)
    );

    // imem_wdata doubles as the byte shift register: it holds the complete
    // word during the imem_we cycle, and a byte arriving in that same cycle
    // only shifts in at its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_lo     <= '0;
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
`ifdef BOOT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (sync_hit) begin
                        state     <= S_LEN_LO;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        err_code  <= ERR_NONE;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                        imem_addr <= '0;
`ifdef BOOT_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end

                S_LEN_LO: begin
                    if (rx_wr) begin
                        len_lo <= rx_data;
                        state  <= S_LEN_HI;
`ifdef BOOT_CHECKSUM_EN
                        csum   <= csum ^ rx_data;
`endif
                    end
                end

                S_LEN_HI: begin
                    if (rx_wr) begin
                        len <= len_next[15:0];
`ifdef BOOT_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (len_next > MAX_WORDS) begin
                            state    <= S_ERROR;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= ERR_LEN;
                        end else if (len_next == '0) begin
`ifdef BOOT_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (rx_wr) begin
                        imem_wdata <= {rx_data, imem_wdata[31:8]};
                        byte_idx   <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        csum       <= csum ^ rx_data;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_addr <= word_cnt[ADDR_WIDTH-1:0];
                            word_cnt  <= word_cnt + CNT_W'(1);
                            if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end
                        end
                    end
                end

`ifdef BOOT_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_wr) begin
                        busy <= 1'b0;
                        if (rx_data == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Expiry is suppressed whenever rx_wr is high, so it never
            // competes with the byte handling above.
            if (tmo_expired) begin
                state    <= S_ERROR;
                busy     <= 1'b0;
                done     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule
